// File: rtl/debug_pkg.sv
// Shared debug-unit definitions: dump FSM state encodings and default word/byte geometry.
package debug_pkg;

    localparam int NB_DATA_DEF    = 32;
    localparam int NB_BYTE_DEF    = 8;
    localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_NEXT  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ADDR  = ST_ADDR,
        S_LATCH = ST_LATCH,
        S_SEND  = ST_SEND,
        S_WAIT  = ST_WAIT,
        S_NEXT  = ST_NEXT,
        S_DONE  = ST_DONE
    } dump_state_t;

endpackage

// File: rtl/reg_word_serializer.sv
// Holds one latched register word and walks its bytes LSB first.
module reg_word_serializer
    import debug_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_BYTE = NB_BYTE_DEF
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic               advance_i,
    input  logic [NB_DATA-1:0] data_i,
    output logic [NB_BYTE-1:0] byte_o,
    output logic               last_byte_o
);

    localparam int BPW    = NB_DATA / NB_BYTE;
    localparam int NB_IDX = (BPW > 1) ? $clog2(BPW) : 1;

    logic [NB_DATA-1:0] word;
    logic [NB_IDX-1:0]  byte_idx;
    logic [NB_DATA-1:0] word_shifted;

    always_ff @(posedge clock_i) begin
        if (reset_i || clear_i) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (load_i) begin
            word     <= data_i;
            byte_idx <= '0;
        end else if (advance_i) begin
            byte_idx <= byte_idx + 1'b1;
        end
    end

    assign word_shifted = word >> (int'(byte_idx) * NB_BYTE);
    assign byte_o       = word_shifted[NB_BYTE-1:0];
    assign last_byte_o  = (byte_idx == NB_IDX'(BPW - 1));

endmodule

// File: rtl/reg_dump_sequencer.sv
// Walks the register bank through the debug mux and streams every word to UART TX, LSB byte first.
// Optional trailing XOR checksum byte when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_sequencer
    import debug_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_BYTE = 8,
    parameter int N_REGS  = 32
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               dump_start_i,
    input  logic [NB_DATA-1:0] data_ra_i,
    input  logic               tx_done_i,
    output logic               select_debug_o,
    output logic [NB_REG-1:0]  addr_reg_debug_o,
    output logic [NB_BYTE-1:0] tx_data_o,
    output logic               tx_start_o,
    output logic               busy_o,
    output logic               dump_done_o
);

    dump_state_t        state, state_nxt;
    logic [NB_REG-1:0]  reg_idx;
    logic               last_reg;
    logic [NB_BYTE-1:0] ser_byte;
    logic               last_byte;
    logic               csum_phase;
    logic [NB_BYTE-1:0] csum;

    // Compare against the final index so N_REGS == 2**NB_REG never relies on wrap-around
    assign last_reg = (reg_idx == NB_REG'(N_REGS - 1));

    reg_word_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .clear_i     (state_nxt == S_IDLE),
        .load_i      (state == S_LATCH),
        .advance_i   ((state == S_WAIT) && tx_done_i && !last_byte && !csum_phase),
        .data_i      (data_ra_i),
        .byte_o      (ser_byte),
        .last_byte_o (last_byte)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state   <= S_IDLE;
            reg_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_IDLE)
                reg_idx <= '0;
            else if ((state == S_NEXT) && !last_reg)
                reg_idx <= reg_idx + 1'b1;
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    always_ff @(posedge clock_i) begin
        if (reset_i || (state_nxt == S_IDLE)) begin
            csum       <= '0;
            csum_phase <= 1'b0;
        end else begin
            if ((state == S_SEND) && !csum_phase)
                csum <= csum ^ ser_byte;
            if ((state == S_NEXT) && last_reg)
                csum_phase <= 1'b1;
        end
    end
`else
    assign csum       = '0;
    assign csum_phase = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (dump_start_i) state_nxt = S_ADDR;
            S_ADDR:  state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_SEND;
            S_SEND:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (tx_done_i) begin
                    if (csum_phase)     state_nxt = S_DONE;
                    else if (last_byte) state_nxt = S_NEXT;
                    else                state_nxt = S_SEND;
                end
            end
            S_NEXT: begin
                if (!last_reg)
                    state_nxt = S_ADDR;
                else begin
`ifdef REG_DUMP_CHECKSUM_EN
                    state_nxt = S_SEND;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o           = (state != S_IDLE);
        select_debug_o   = (state != S_IDLE);
        addr_reg_debug_o = reg_idx;
        tx_start_o       = (state == S_SEND);
        dump_done_o      = (state == S_DONE);
        tx_data_o        = '0;
        if ((state == S_SEND) || (state == S_WAIT))
            tx_data_o = csum_phase ? csum : ser_byte;
    end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Directed bench for reg_dump_sequencer: bank model, UART TX model, vector table plus corner sequences.
module tb_reg_dump_sequencer;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_BYTE = 8;
    localparam int N_REGS  = 32;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int EXP_BYTES     = 129;
    localparam int EXP_DONE_TICK = 612;
`else
    localparam int EXP_BYTES     = 128;
    localparam int EXP_DONE_TICK = 608;
`endif

    logic               clock_i = 1'b0;
    logic               reset_i;
    logic               dump_start_i;
    logic [NB_DATA-1:0] data_ra_i;
    logic               tx_done_i;
    logic               select_debug_o;
    logic [NB_REG-1:0]  addr_reg_debug_o;
    logic [NB_BYTE-1:0] tx_data_o;
    logic               tx_start_o;
    logic               busy_o;
    logic               dump_done_o;

    logic        model_done = 1'b0;
    logic        inj_done   = 1'b0;
    logic        idle_done  = 1'b0;
    logic        inj_mode   = 1'b0;
    logic [31:0] bank [N_REGS];
    logic [7:0]  rx_q [$];
    int          done_cnt = 0;
    int          tx_cnt   = 0;
    int          checks   = 0;
    int          failures = 0;

    typedef struct {
        int          reg_num;
        logic [31:0] word;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;
    vec_t vecs [5];

    assign data_ra_i = bank[addr_reg_debug_o];
    assign tx_done_i = model_done | inj_done | idle_done;

    reg_dump_sequencer #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG),
        .NB_BYTE (NB_BYTE),
        .N_REGS  (N_REGS)
    ) dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .dump_start_i     (dump_start_i),
        .data_ra_i        (data_ra_i),
        .tx_done_i        (tx_done_i),
        .select_debug_o   (select_debug_o),
        .addr_reg_debug_o (addr_reg_debug_o),
        .tx_data_o        (tx_data_o),
        .tx_start_o       (tx_start_o),
        .busy_o           (busy_o),
        .dump_done_o      (dump_done_o)
    );

    always #5 clock_i = ~clock_i;

    // UART TX model: done pulse in the third cycle after tx_start
    initial begin
        forever begin
            @(negedge clock_i);
            model_done = 1'b0;
            inj_done   = 1'b0;
            if (reset_i === 1'b1) begin
                tx_cnt = 0;
            end else begin
                if (tx_cnt > 0) begin
                    tx_cnt = tx_cnt - 1;
                    if (tx_cnt == 0) model_done = 1'b1;
                end
                if (tx_start_o) begin
                    rx_q.push_back(tx_data_o);
                    tx_cnt = 3;
                    if (inj_mode) inj_done = 1'b1;
                end
                if (dump_done_o) done_cnt++;
            end
        end
    end

    task automatic tick();
        @(negedge clock_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {16'h0, select_debug_o, addr_reg_debug_o, tx_data_o, tx_start_o, busy_o, dump_done_o}, 32'h0);
    endtask

    task automatic load_bank();
        for (int i = 0; i < N_REGS; i++) bank[i] = 32'h0;
        for (int i = 0; i < 5; i++) bank[vecs[i].reg_num] = vecs[i].word;
    endtask

    task automatic check_table(input string tag);
        if (rx_q.size() < N_REGS * 4) begin
            check({tag, "_size"}, rx_q.size(), N_REGS * 4);
        end else begin
            for (int i = 0; i < 5; i++) begin
                int b;
                b = vecs[i].reg_num * 4;
                check($sformatf("%s_r%0d_b0", tag, vecs[i].reg_num), {24'h0, rx_q[b]},   {24'h0, vecs[i].b0});
                check($sformatf("%s_r%0d_b1", tag, vecs[i].reg_num), {24'h0, rx_q[b+1]}, {24'h0, vecs[i].b1});
                check($sformatf("%s_r%0d_b2", tag, vecs[i].reg_num), {24'h0, rx_q[b+2]}, {24'h0, vecs[i].b2});
                check($sformatf("%s_r%0d_b3", tag, vecs[i].reg_num), {24'h0, rx_q[b+3]}, {24'h0, vecs[i].b3});
            end
        end
    endtask

    task automatic wait_done(input int target, input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done_cnt, target);
    endtask

    task automatic run_dump(input string tag);
        rx_q.delete();
        done_cnt     = 0;
        dump_start_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        wait_done(1, tag);
        tick();
        check({tag, "_single_done"}, done_cnt, 1);
        check({tag, "_idle_after"}, {31'h0, busy_o}, 32'h0);
        check({tag, "_byte_count"}, rx_q.size(), EXP_BYTES);
    endtask

    initial begin
        int n;
        vecs[0] = '{0,  32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{1,  32'h11223344, 8'h44, 8'h33, 8'h22, 8'h11};
        vecs[2] = '{5,  32'hA5A50F0F, 8'h0F, 8'h0F, 8'hA5, 8'hA5};
        vecs[3] = '{7,  32'h000000FF, 8'hFF, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{31, 32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        load_bank();

        reset_i      = 1'b1;
        dump_start_i = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset_outputs");
        reset_i = 1'b0;
        tick();
        check_idle_outputs("idle_outputs");

        // Basic dump with first-cycle sequencing and total latency
        rx_q.delete();
        done_cnt     = 0;
        dump_start_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        check("t1_addr_busy", {30'h0, busy_o, select_debug_o}, 32'h3);
        check("t1_addr_idx", {27'h0, addr_reg_debug_o}, 32'h0);
        check("t1_addr_nostart", {31'h0, tx_start_o}, 32'h0);
        tick();
        check("t1_latch_nostart", {31'h0, tx_start_o}, 32'h0);
        tick();
        check("t1_send_start", {31'h0, tx_start_o}, 32'h1);
        tick();
        check("t1_wait_nostart", {31'h0, tx_start_o}, 32'h0);
        n = 3;
        while (done_cnt == 0 && n < 3000) begin
            tick();
            n++;
        end
        check("t1_done_tick", n, EXP_DONE_TICK);
        check("t1_done_pulse", {31'h0, dump_done_o}, 32'h1);
        tick();
        check("t1_done_cleared", {31'h0, dump_done_o}, 32'h0);
        check("t1_single_done", done_cnt, 1);
        check_idle_outputs("t1_idle_outputs");
        check("t1_byte_count", rx_q.size(), EXP_BYTES);
        check_table("t1");

        // Stray tx_done in IDLE and in every SEND
        idle_done = 1'b1;
        tick();
        idle_done = 1'b0;
        check_idle_outputs("t2_idle_done_ignored");
        inj_mode = 1'b1;
        run_dump("t2");
        inj_mode = 1'b0;
        check_table("t2");

        // Reset in WAIT of r5 byte 2, then a clean restart
        rx_q.delete();
        dump_start_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        n = 0;
        while (!(rx_q.size() == 23 && tx_start_o == 1'b0) && n < 3000) begin
            tick();
            n++;
        end
        check("t3_reached_r5_b2", rx_q.size(), 23);
        check("t3_addr_r5", {27'h0, addr_reg_debug_o}, 32'h5);
        check("t3_byte_r5_b2", {24'h0, tx_data_o}, 32'hA5);
        reset_i = 1'b1;
        tick();
        check_idle_outputs("t3_reset_outputs");
        reset_i = 1'b0;
        tick();
        check_idle_outputs("t3_post_reset_idle");
        run_dump("t3");
        check_table("t3");

        // dump_start held through a whole dump
        rx_q.delete();
        done_cnt     = 0;
        dump_start_i = 1'b1;
        tick();
        wait_done(1, "t4_first");
        check("t4_busy_in_done", {31'h0, busy_o}, 32'h1);
        tick();
        check("t4_idle_gap", {31'h0, busy_o}, 32'h0);
        check("t4_one_dump_bytes", rx_q.size(), EXP_BYTES);
        tick();
        check("t4_restart_busy", {31'h0, busy_o}, 32'h1);
        check("t4_restart_addr", {27'h0, addr_reg_debug_o}, 32'h0);
        dump_start_i = 1'b0;
        wait_done(2, "t4_second");
        tick();
        check("t4_second_bytes", rx_q.size(), 2 * EXP_BYTES);
        check("t4_final_idle", {31'h0, busy_o}, 32'h0);

        // Bank changes right after LATCH of r7 must not leak into the bytes
        rx_q.delete();
        done_cnt     = 0;
        dump_start_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        n = 0;
        while (addr_reg_debug_o != 5'd7 && n < 3000) begin
            tick();
            n++;
        end
        check("t5_reached_r7", {27'h0, addr_reg_debug_o}, 32'h7);
        tick();
        @(posedge clock_i);
        #1;
        bank[7] = 32'h12345678;
        wait_done(1, "t5");
        tick();
        check("t5_byte_count", rx_q.size(), EXP_BYTES);
        check_table("t5");
        bank[7] = 32'h000000FF;

`ifdef REG_DUMP_CHECKSUM_EN
        for (int i = 0; i < N_REGS; i++) bank[i] = 32'h01010101;
        run_dump("t6a");
        if (rx_q.size() == 129) check("t6a_checksum", {24'h0, rx_q[128]}, 32'h00);
        bank[1] = 32'h000000FF;
        run_dump("t6b");
        if (rx_q.size() == 129) check("t6b_checksum", {24'h0, rx_q[128]}, 32'hFF);
        load_bank();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
